// File: rtl/tmds_timing_gen.sv
// tmds_timing_gen: free-running CEA 720p TX raster timing generator; genlock to ext_vsync when TIMING_GENLOCK_EN is defined
module tmds_timing_gen #(
  parameter int   H_SYNC    = 40,
  parameter int   H_BP      = 220,
  parameter int   H_ACTIVE  = 1280,
  parameter int   H_TOTAL   = 1650,
  parameter int   V_SYNC    = 5,
  parameter int   V_BP      = 20,
  parameter int   V_ACTIVE  = 720,
  parameter int   V_TOTAL   = 750,
  parameter int   H_IDX_MID = 600,
  parameter logic SYNC_POL  = 1'b1
) (
  input  logic        tx0_pclk,
  input  logic        rstbtn_n,
`ifdef TIMING_GENLOCK_EN
  input  logic        ext_vsync,
`endif
  output logic        hsync,
  output logic        vsync,
  output logic        pix_req,
  output logic        video_en,
  output logic        hactive,
  output logic        vactive,
  output logic [10:0] video_hcnt,
  output logic [10:0] video_vcnt,
  output logic [11:0] index,
  output logic        frame_start
);
  localparam logic [10:0] HS  = 11'(H_SYNC);
  localparam logic [10:0] HA0 = 11'(H_SYNC + H_BP);
  localparam logic [10:0] HA1 = 11'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [10:0] HP0 = 11'(H_SYNC + H_BP - 1);
  localparam logic [10:0] HM  = 11'(H_SYNC + H_BP + H_IDX_MID - 1);
  localparam logic [10:0] HT  = 11'(H_TOTAL - 1);
  localparam logic [10:0] VS  = 11'(V_SYNC);
  localparam logic [10:0] VA0 = 11'(V_SYNC + V_BP);
  localparam logic [10:0] VA1 = 11'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [10:0] VT  = 11'(V_TOTAL - 1);
  logic [10:0] hcnt, vcnt, hn, vn;
  logic        load, hw, ha, va, pa;
`ifdef TIMING_GENLOCK_EN
  logic [2:0] ext_sr;
  always_ff @(posedge tx0_pclk)
    ext_sr <= rstbtn_n ? 3'b000 : {ext_sr[1:0], ext_vsync};
  assign load = ext_sr[1] & ~ext_sr[2];
`else
  assign load = 1'b0;
`endif
  always_comb begin
    hw = hcnt == HT;
    hn = (load | hw) ? 11'd0 : hcnt + 11'd1;
    vn = (load | (hw & (vcnt == VT))) ? 11'd0 : hw ? vcnt + 11'd1 : vcnt;
    ha = (hcnt >= HA0) && (hcnt < HA1);
    va = (vcnt >= VA0) && (vcnt < VA1);
    pa = (hn >= HA0) && (hn < HA1) && (vn >= VA0) && (vn < VA1);
  end
  always_ff @(posedge tx0_pclk) begin
    if (rstbtn_n) begin
      hcnt        <= '0;
      vcnt        <= '0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      pix_req     <= 1'b0;
      video_en    <= 1'b0;
      hactive     <= 1'b0;
      vactive     <= 1'b0;
      video_hcnt  <= '0;
      video_vcnt  <= '0;
      index       <= '0;
      frame_start <= 1'b0;
    end else begin
      hcnt        <= hn;
      vcnt        <= vn;
      hsync       <= (hcnt < HS) ? SYNC_POL : ~SYNC_POL;
      vsync       <= (vcnt < VS) ? SYNC_POL : ~SYNC_POL;
      pix_req     <= pa;
      video_en    <= ha & va;
      hactive     <= ha;
      vactive     <= va;
      video_hcnt  <= (ha & va) ? hcnt - HA0 : 11'd0;
      video_vcnt  <= va ? vcnt - VA0 : 11'd0;
      index       <= ((hcnt == HP0) && (vcnt == VA0)) ? 12'd0 :
                     ((hcnt == HP0) || (hcnt == HM)) ? index + 12'd1 : index;
      frame_start <= (hcnt == 11'd0) && (vcnt == 11'd0);
    end
  end
endmodule

// File: tb/tb_tmds_timing_gen.sv
// tb_tmds_timing_gen: checks tmds_timing_gen on a reduced raster against a position-based model plus literal timing measurements
module tb_tmds_timing_gen;
  localparam int HS = 4, HBP = 6, HA = 16, HT = 30;
  localparam int VS = 2, VBP = 3, VA = 8, VT = 16, MID = 10;
  localparam int HA0 = HS + HBP, VA0 = VS + VBP, FRAME = HT * VT;
  logic clk = 1'b0, rst = 1'b1, ext = 1'b0;
  logic hsync, vsync, pix_req, video_en, hactive, vactive, frame_start;
  logic [10:0] video_hcnt, video_vcnt;
  logic [11:0] index;
  int tests = 0, fails = 0;
  int mh, mv, midx;
  logic h0, h1, h2, h3;
  always #5 clk = ~clk;
  tmds_timing_gen #(
    .H_SYNC(HS), .H_BP(HBP), .H_ACTIVE(HA), .H_TOTAL(HT),
    .V_SYNC(VS), .V_BP(VBP), .V_ACTIVE(VA), .V_TOTAL(VT),
    .H_IDX_MID(MID), .SYNC_POL(1'b1)
  ) dut (
    .tx0_pclk(clk), .rstbtn_n(rst),
`ifdef TIMING_GENLOCK_EN
    .ext_vsync(ext),
`endif
    .hsync(hsync), .vsync(vsync), .pix_req(pix_req), .video_en(video_en),
    .hactive(hactive), .vactive(vactive), .video_hcnt(video_hcnt),
    .video_vcnt(video_vcnt), .index(index), .frame_start(frame_start)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic sig(input int s);
    case (s)
      0: sig = frame_start;
      1: sig = hsync;
      2: sig = video_en;
      default: sig = 1'b0;
    endcase
  endfunction
  task automatic run_len(input int s, input logic v, output int n);
    n = 0;
    while (sig(s) === v && n < 2000) begin
      @(negedge clk);
      n++;
    end
  endtask
  initial begin : model
    logic rs, ev, ld, have_prev, prev_pix, e_ha, e_va;
    have_prev = 1'b0;
    prev_pix = 1'b0;
    forever begin
      @(posedge clk);
      rs = rst;
      ev = ext;
      @(negedge clk);
      if (rs) begin
        {mh, mv, midx} = '0;
        {h0, h1, h2, h3} = 4'b0;
        e_ha = 1'b0;
        e_va = 1'b0;
        chk("rst_hsync", hsync, 0);
        chk("rst_vsync", vsync, 0);
        chk("rst_fs", frame_start, 0);
        chk("rst_pixreq", pix_req, 0);
        chk("rst_vhcnt", video_hcnt, 0);
        chk("rst_vvcnt", video_vcnt, 0);
        chk("rst_index", index, 0);
      end else begin
        {h3, h2, h1, h0} = {h2, h1, h0, ev};
        ld = h2 & ~h3;
        e_ha = mh >= HA0 && mh < HA0 + HA;
        e_va = mv >= VA0 && mv < VA0 + VA;
        if (mh == HA0 - 1 && mv == VA0) midx = 0;
        else if (mh == HA0 - 1 || mh == HA0 + MID - 1) midx = (midx + 1) % 4096;
        chk("hsync", hsync, mh < HS);
        chk("vsync", vsync, mv < VS);
        chk("fs", frame_start, mh == 0 && mv == 0);
        chk("vhcnt", video_hcnt, (e_ha && e_va) ? mh - HA0 : 0);
        chk("vvcnt", video_vcnt, e_va ? mv - VA0 : 0);
        chk("index", index, midx);
        if (have_prev) chk("pixreq_lead", prev_pix, e_ha & e_va);
        mv = ld ? 0 : (mh == HT - 1) ? (mv + 1) % VT : mv;
        mh = ld ? 0 : (mh + 1) % HT;
      end
      chk("hactive", hactive, e_ha);
      chk("vactive", vactive, e_va);
      chk("video_en", video_en, e_ha & e_va);
      if (video_en && video_vcnt == 0 && video_hcnt == MID - 2) chk("idx_first_half", index, 0);
      if (video_en && video_vcnt == 0 && video_hcnt == MID - 1) chk("idx_after_mid", index, 1);
      if (video_en && video_vcnt == VA - 1 && video_hcnt == HA - 1) chk("idx_last_line", index, 2 * VA - 1);
      prev_pix = pix_req;
      have_prev = 1'b1;
    end
  end
  initial begin : stim
    int n, lines, vmax, vsn;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("first_fs", frame_start, 1);
    chk("first_hsync", hsync, 1);
    run_len(0, 1, n);
    chk("fs_width", n, 1);
    run_len(0, 0, n);
    chk("fs_period", n + 1, FRAME);
    run_len(2, 0, n);
    chk("ven_first_vvcnt", video_vcnt, 0);
    run_len(2, 1, n);
    chk("ven_width", n, HA);
    run_len(1, 0, n);
    run_len(1, 1, n);
    chk("hsync_width", n, HS);
    run_len(1, 0, n);
    chk("hsync_period", n + HS, HT);
    run_len(2, 0, n);
    chk("hs_to_ven", n, HA0);
    run_len(0, 0, n);
    lines = 0;
    vmax = 0;
    vsn = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (video_en && video_hcnt == 0) lines++;
      if (video_vcnt > vmax) vmax = video_vcnt;
      if (vsync) vsn++;
      @(negedge clk);
    end
    chk("ven_lines", lines, VA);
    chk("vvcnt_max", vmax, VA - 1);
    chk("vsync_width", vsn, VS * HT);
    chk("wrap_fs", frame_start, 1);
    chk("wrap_vvcnt", video_vcnt, 0);
    n = 0;
    while (!(video_en && video_vcnt == 2 && video_hcnt == 3) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_mid_frame", n < 2000, 1);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_ven", video_en, 0);
      chk("midrst_vsync", vsync, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("restart_fs", frame_start, 1);
    chk("restart_hsync", hsync, 1);
    chk("restart_vsync", vsync, 1);
    run_len(0, 1, n);
    run_len(0, 0, n);
    chk("restart_period", n + 1, FRAME);
`ifdef TIMING_GENLOCK_EN
    repeat (8 * HT + 5) @(negedge clk);
    ext = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 2000);
    chk("genlock_latency", n, 4);
    run_len(0, 1, n);
    ext = 1'b0;
    run_len(0, 0, n);
    chk("genlock_period", n + 1, FRAME);
`endif
    repeat (50) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
